// File: rtl/seven_seg_scan_display.sv
// Multiplexed NUM_DIGITS-digit 7-segment controller with a double-dabble binary-to-BCD engine.
// Optional macro HEX_MODE_EN adds a hex_mode input that shows raw nibbles as 0-F.
module seven_seg_scan_display #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DIGIT_TICKS = 262144
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_W-1:0]     load_value,
  input  logic                  blank_en,
`ifdef HEX_MODE_EN
  input  logic                  hex_mode,
`endif
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] Anode_Activate,
  output logic [6:0]            LED_out
);

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam int unsigned BCD_N   = (DATA_W * 30103 + 99999) / 100000 + 1;
  localparam int unsigned ACC_N   = (BCD_N > NUM_DIGITS) ? BCD_N : NUM_DIGITS;
  localparam int unsigned ACC_W   = 4 * ACC_N;
  localparam int unsigned DISP_W  = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W   = $clog2(DATA_W) + 1;
  localparam int unsigned TICK_W  = $clog2(DIGIT_TICKS);
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] DEC_MAX = pow10(NUM_DIGITS) - 64'd1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Active-low {a,b,c,d,e,f,g}; anything undefined stays dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
`ifdef HEX_MODE_EN
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      4'hF:    s = 7'b0111000;
`endif
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [ACC_W-1:0]  bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovp_q, ovp_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic              ov_q, ov_d;
  logic              ready_q, ready_d;
  logic              dec_ov;

  assign dec_ov = 64'(load_value) > DEC_MAX;

`ifdef HEX_MODE_EN
  localparam int unsigned VEXT_W = (DATA_W > DISP_W) ? DATA_W : DISP_W;
  logic [VEXT_W-1:0] val_ext;
  assign val_ext = VEXT_W'(load_value);
`endif

  // Converter state register.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Converter next-state and datapath; a hex load bypasses SHIFT entirely.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovp_d   = ovp_q;
    disp_d  = disp_q;
    ov_d    = ov_q;
    ready_d = ready_q;
    adj     = bcd_q;
    for (int i = 0; i < int'(ACC_N); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      ST_IDLE: begin
        if (load_valid && ready_q) begin
          bin_d   = load_value;
          bcd_d   = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          ovp_d   = dec_ov;
          state_d = ST_SHIFT;
`ifdef HEX_MODE_EN
          if (hex_mode) begin
            bcd_d[DISP_W-1:0] = val_ext[DISP_W-1:0];
            ovp_d             = |(val_ext >> DISP_W);
            state_d           = ST_COMMIT;
          end
`endif
        end
      end
      ST_SHIFT: begin
        bcd_d = ACC_W'({adj, bin_q[DATA_W-1]});
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        disp_d  = bcd_q[DISP_W-1:0];
        ov_d    = ovp_q;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovp_q   <= 1'b0;
      disp_q  <= '0;
      ov_q    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovp_q   <= ovp_d;
      disp_q  <= disp_d;
      ov_q    <= ov_d;
      ready_q <= ready_d;
    end
  end

  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            led_q, led_d;
  logic [3:0]            cur_nib;
  logic                  lead_zero;

  // Scan timing: dwell DIGIT_TICKS cycles per digit, index 0 is leftmost.
  always_comb begin
    tick_d = tick_q + TICK_W'(1);
    idx_d  = idx_q;
    if (tick_q == TICK_W'(DIGIT_TICKS - 1)) begin
      tick_d = '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) idx_d = '0;
      else                                 idx_d = idx_q + IDX_W'(1);
    end
  end

  // Next registered anode/segment pattern for the digit currently indexed.
  always_comb begin
    anode_d   = '1;
    cur_nib   = 4'd0;
    lead_zero = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (IDX_W'(i) == idx_q) begin
        anode_d[NUM_DIGITS-1-i] = 1'b0;
        cur_nib                 = disp_q[4*(NUM_DIGITS-1-i) +: 4];
      end
      if ((IDX_W'(i) <= idx_q) && (disp_q[4*(NUM_DIGITS-1-i) +: 4] != 4'd0)) lead_zero = 1'b0;
    end
    if (ov_q)
      led_d = SEG_DASH;
    else if (blank_en && lead_zero && (idx_q != IDX_W'(NUM_DIGITS - 1)))
      led_d = SEG_BLANK;
    else
      led_d = seg_decode(cur_nib);
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      tick_q  <= '0;
      idx_q   <= '0;
      anode_q <= '1;
      led_q   <= SEG_BLANK;
    end else begin
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      led_q   <= led_d;
    end
  end

  assign load_ready     = ready_q;
  assign overflow       = ov_q;
  assign Anode_Activate = anode_q;
  assign LED_out        = led_q;

endmodule

// File: tb/tb_seven_seg_scan_display.sv
// Scoreboard bench for seven_seg_scan_display: stimulus pushes expected loads, a negedge
// monitor pops them on conversion completion and checks every scanned digit against a model.
module tb_seven_seg_scan_display;
  localparam int unsigned N = 4;
  localparam int unsigned W = 16;
  localparam int unsigned T = 4;

  logic         clock_100Mhz = 1'b0;
  logic         reset        = 1'b1;
  logic         load_valid   = 1'b0;
  logic [W-1:0] load_value   = '0;
  logic         blank_en     = 1'b0;
`ifdef HEX_MODE_EN
  logic         hex_mode     = 1'b0;
`endif
  logic         load_ready;
  logic         overflow;
  logic [N-1:0] Anode_Activate;
  logic [6:0]   LED_out;

  always #5 clock_100Mhz = ~clock_100Mhz;

  seven_seg_scan_display #(.NUM_DIGITS(N), .DATA_W(W), .DIGIT_TICKS(T)) dut (
    .clock_100Mhz  (clock_100Mhz),
    .reset         (reset),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_value    (load_value),
    .blank_en      (blank_en),
`ifdef HEX_MODE_EN
    .hex_mode      (hex_mode),
`endif
    .overflow      (overflow),
    .Anode_Activate(Anode_Activate),
    .LED_out       (LED_out)
  );

  typedef struct { int unsigned val; bit hex; } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Model of what the display currently holds.
  int unsigned cur_val = 0;
  bit          cur_hex = 1'b0;

  bit rst_pending = 1'b1;
  bit started     = 1'b0;
  bit prev_ready  = 1'b1;
  bit prev_blank  = 1'b0;
  int k    = 0;
  int busy = 0;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic bit model_ov(input int unsigned v, input bit hx);
    if (hx) return (v >> (4 * N)) != 0;
    return v > pow10(N) - 1;
  endfunction

  // Digit i counted from the left.
  function automatic int unsigned model_digit(input int unsigned v, input bit hx, input int i);
    if (hx) return (v >> (4 * (N - 1 - i))) & 15;
    return (v / pow10(N - 1 - i)) % 10;
  endfunction

  function automatic logic [6:0] glyph(input int unsigned d);
    case (d)
      0:  return 7'b0000001;
      1:  return 7'b1001111;
      2:  return 7'b0010010;
      3:  return 7'b0000110;
      4:  return 7'b1001100;
      5:  return 7'b0100100;
      6:  return 7'b0100000;
      7:  return 7'b0001111;
      8:  return 7'b0000000;
      9:  return 7'b0000100;
      10: return 7'b0001000;
      11: return 7'b1100000;
      12: return 7'b0110001;
      13: return 7'b1000010;
      14: return 7'b0110000;
      15: return 7'b0111000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int unsigned v, input bit hx, input bit bl, input int i);
    bit lz = 1'b1;
    if (model_ov(v, hx)) return 7'b1111110;
    if (bl && i < int'(N) - 1) begin
      for (int j = 0; j <= i; j++) if (model_digit(v, hx, j) != 0) lz = 1'b0;
      if (lz) return 7'b1111111;
    end
    return glyph(model_digit(v, hx, i));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor: outputs after each rising edge, sampled on the falling edge.
  always @(negedge clock_100Mhz) begin : monitor
    logic [N-1:0] ea;
    int           idx;
    exp_t         e;
    if (rst_pending) begin
      check("rst_load_ready", 32'(load_ready), 32'd1);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_anodes", 32'(Anode_Activate), 32'({N{1'b1}}));
      check("rst_led", 32'(LED_out), 32'h7F);
      exp_q.delete();
      cur_val = 0;
      cur_hex = 1'b0;
      busy    = 0;
      k       = 0;
      started = 1'b1;
    end else if (started) begin
      k++;
      idx = ((k - 1) / int'(T)) % int'(N);
      ea = '1;
      ea[int'(N) - 1 - idx] = 1'b0;
      check("anode_scan", 32'(Anode_Activate), 32'(ea));
      check("led_digit", 32'(LED_out), 32'(model_seg(cur_val, cur_hex, prev_blank, idx)));
      if (!load_ready) begin
        busy++;
      end else if (!prev_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got completion, want none pending (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("overflow", 32'(overflow), 32'(model_ov(e.val, e.hex)));
          check("busy_cycles", 32'(busy), e.hex ? 32'd1 : 32'(W + 1));
          cur_val = e.val;
          cur_hex = e.hex;
        end
        busy = 0;
      end
    end
    rst_pending = reset;
    prev_ready  = load_ready;
    prev_blank  = blank_en;
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (!load_ready && n < 200) begin
      @(posedge clock_100Mhz);
      #1;
      n++;
    end
    if (!load_ready) begin
      checks++;
      errors++;
      $display("FAIL %s: load_ready=0 after %0d cycles, want 1", name, n);
    end
  endtask

  task automatic do_load(input int unsigned v, input bit bl, input bit hx);
    int unsigned vm;
    wait_idle("ready_timeout");
    vm         = v & ((32'd1 << W) - 1);
    load_value = W'(vm);
    blank_en   = bl;
`ifdef HEX_MODE_EN
    hex_mode   = hx;
`endif
    load_valid = 1'b1;
    exp_q.push_back('{val: vm, hex: hx});
    @(posedge clock_100Mhz);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_scan();
    wait_idle("done_timeout");
    repeat (N * T + 2) @(posedge clock_100Mhz);
    #1;
  endtask

  initial begin
    bit bl;
    bit hx;
    int unsigned v;
    repeat (3) @(posedge clock_100Mhz);
    #1;
    reset = 1'b0;
    repeat (2 * N * T) @(posedge clock_100Mhz);
    #1;

    do_load(1234, 1'b0, 1'b0);   wait_scan();
    do_load(7, 1'b1, 1'b0);      wait_scan();
    do_load(0, 1'b1, 1'b0);      wait_scan();
    do_load(12345, 1'b0, 1'b0);  wait_scan();
    do_load(9999, 1'b0, 1'b0);   wait_scan();
    do_load(120, 1'b1, 1'b0);    wait_scan();

    // A request while busy must be dropped.
    do_load(5678, 1'b0, 1'b0);
    repeat (3) @(posedge clock_100Mhz);
    #1;
    load_value = W'(42);
    load_valid = 1'b1;
    @(posedge clock_100Mhz);
    #1;
    load_valid = 1'b0;
    wait_scan();

    // Reset part-way through SHIFT discards the conversion and the display.
    do_load(4321, 1'b0, 1'b0);
    repeat (7) @(posedge clock_100Mhz);
    #1;
    reset = 1'b1;
    @(posedge clock_100Mhz);
    #1;
    reset = 1'b0;
    wait_scan();

`ifdef HEX_MODE_EN
    do_load(32'hBEEF, 1'b0, 1'b1); wait_scan();
    do_load(32'h00A0, 1'b1, 1'b1); wait_scan();
`endif

    for (int i = 0; i < 30; i++) begin
      v  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 65535);
      bl = 1'($urandom_range(0, 1));
      hx = 1'b0;
`ifdef HEX_MODE_EN
      hx = 1'($urandom_range(0, 1));
`endif
      do_load(v, bl, hx);
      wait_scan();
    end

    repeat (4) @(posedge clock_100Mhz);
    #1;
    check("pending_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
